// File: rtl/crc_check_rx_pkg.sv
// -----------------------------------------------------------------------------
// crc_check_rx_pkg
// Shared types for the serial CRC checker: the frame-level FSM state encoding.
// -----------------------------------------------------------------------------
package crc_check_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage : crc_check_rx_pkg

// File: rtl/crc_check_rx_comb.sv
// -----------------------------------------------------------------------------
// crc_comb
// Single-bit combinational CRC step, shared with the bit-serial generator.
//
// Ports:
//   crc_i        current CRC register
//   data_i       serial data bit
//   poly_i       generator polynomial
//   poly_size_i  polynomial size select (only bits enabled in MASK take effect)
//   crc_o        register value after absorbing data_i
// -----------------------------------------------------------------------------
module crc_comb #(
    parameter int                  CRC_SIZE = 8,
    parameter logic [CRC_SIZE-1:0] MASK     = 8'hff
) (
    input  logic [CRC_SIZE-1:0] crc_i,
    input  logic                data_i,
    input  logic [CRC_SIZE-1:0] poly_i,
    input  logic [CRC_SIZE-2:0] poly_size_i,
    output logic [CRC_SIZE-1:0] crc_o
);

    logic [CRC_SIZE-1:0] fb;
    logic [CRC_SIZE-2:0] clr;
    logic [CRC_SIZE-2:0] keep;

    always_comb begin
        fb = poly_i & {CRC_SIZE{crc_i[CRC_SIZE-1] ^ data_i}};
        // Size select is bit-reversed relative to the register: its MSB clears
        // register bit 0, shrinking the effective CRC from the bottom up.
        for (int i = 0; i < CRC_SIZE - 1; i++) begin
            clr[i] = poly_size_i[CRC_SIZE-2-i] & MASK[CRC_SIZE-2-i];
        end
        keep  = crc_i[CRC_SIZE-2:0] & ~clr;
        crc_o = {keep ^ fb[CRC_SIZE-1:1], fb[0]};
    end

endmodule : crc_comb

// File: rtl/crc_check_rx.sv
// -----------------------------------------------------------------------------
// crc_check_rx
// Receive-side serial CRC checker. Takes payload_len payload bits followed by
// CRC_SIZE transmitted CRC bits (MSB first), recomputes the CRC over the
// payload and reports pass/fail with a one-cycle done strobe.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    frame start (sampled in IDLE only)
//   payload_len              payload bit count, latched at start
//   crc_init/crc_poly        register seed / polynomial, latched at start
//   crc_poly_size            polynomial size select, latched at start
//   abort                    abandon the frame in progress (no done)
//   bit_valid/bit_in         serial bit stream; beat = bit_valid & bit_ready
//   bit_ready                high in PAYLOAD and CHECK
//   busy                     frame in progress (PAYLOAD, CHECK, DONE)
//   done                     one-cycle result strobe
//   crc_ok/crc_err           sticky result of the last frame
//   crc_calc                 computed payload CRC
// -----------------------------------------------------------------------------
module crc_check_rx
    import crc_check_rx_pkg::*;
#(
    parameter int                  CRC_SIZE = 8,
    parameter logic [CRC_SIZE-1:0] MASK     = 8'hff,
    parameter int                  LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    payload_len,
    input  logic [CRC_SIZE-1:0] crc_init,
    input  logic [CRC_SIZE-1:0] crc_poly,
    input  logic [CRC_SIZE-2:0] crc_poly_size,
    input  logic                abort,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic                bit_ready,
    output logic                busy,
    output logic                done,
    output logic                crc_ok,
    output logic                crc_err,
    output logic [CRC_SIZE-1:0] crc_calc
);

    localparam int IDX_W = $clog2(CRC_SIZE);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [CRC_SIZE-1:0] crc_q, crc_d;
    logic [CRC_SIZE-1:0] poly_q, poly_d;
    logic [CRC_SIZE-2:0] size_q, size_d;
    logic                mis_q, mis_d;
    logic                ok_q, ok_d;
    logic                err_q, err_d;

    logic [CRC_SIZE-1:0] crc_step;
    logic                beat;
    logic [IDX_W-1:0]    chk_idx;

    crc_comb #(
        .CRC_SIZE (CRC_SIZE),
        .MASK     (MASK)
    ) u_step (
        .crc_i       (crc_q),
        .data_i      (bit_in),
        .poly_i      (poly_q),
        .poly_size_i (size_q),
        .crc_o       (crc_step)
    );

    assign bit_ready = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign crc_calc  = crc_q;

    assign beat = bit_valid && bit_ready;
    // In CHECK the counter runs CRC_SIZE..1, so cnt-1 is the register bit that
    // the current (MSB-first) transmitted CRC bit must match.
    assign chk_idx = IDX_W'(cnt_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        poly_d  = poly_q;
        size_d  = size_q;
        mis_d   = mis_q;
        ok_d    = ok_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    poly_d = crc_poly;
                    size_d = crc_poly_size;
                    crc_d  = crc_init;
                    mis_d  = 1'b0;
                    ok_d   = 1'b0;
                    err_d  = 1'b0;
                    if (payload_len != '0) begin
                        cnt_d   = payload_len;
                        state_d = ST_PAYLOAD;
                    end else begin
                        cnt_d   = LEN_W'(CRC_SIZE);
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (beat) begin
                    crc_d = crc_step;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        cnt_d   = LEN_W'(CRC_SIZE);
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (beat) begin
                    mis_d = mis_q | (bit_in ^ crc_q[chk_idx]);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        // Result registers take the final mismatch so they are
                        // already valid in the DONE cycle.
                        ok_d    = ~mis_d;
                        err_d   = mis_d;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            crc_q   <= '0;
            poly_q  <= '0;
            size_q  <= '0;
            mis_q   <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            poly_q  <= poly_d;
            size_q  <= size_d;
            mis_q   <= mis_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

endmodule : crc_check_rx

// File: tb/tb_crc_check_rx.sv
module tb_crc_check_rx;

    localparam int          N    = 8;
    localparam int          LW   = 16;
    localparam logic [N-1:0] MASK = 8'hff;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] payload_len;
    logic [N-1:0]  crc_init;
    logic [N-1:0]  crc_poly;
    logic [N-2:0]  crc_poly_size;
    logic          abort;
    logic          bit_valid;
    logic          bit_in;
    logic          bit_ready;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          crc_err;
    logic [N-1:0]  crc_calc;

    crc_check_rx #(
        .CRC_SIZE (N),
        .MASK     (MASK),
        .LEN_W    (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .payload_len   (payload_len),
        .crc_init      (crc_init),
        .crc_poly      (crc_poly),
        .crc_poly_size (crc_poly_size),
        .abort         (abort),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .bit_ready     (bit_ready),
        .busy          (busy),
        .done          (done),
        .crc_ok        (crc_ok),
        .crc_err       (crc_err),
        .crc_calc      (crc_calc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit pl [0:511];

    // Plain shift-register CRC: shift left, drop the bits the size select
    // removes, xor in the polynomial when the outgoing bit differs from data.
    function automatic logic [N-1:0] model_crc(input int len, input logic [N-1:0] init,
                                               input logic [N-1:0] poly, input logic [N-2:0] sz);
        logic [N-1:0] r;
        logic [N-1:0] hold;
        logic         f;
        r       = init;
        hold[0] = 1'b0;
        for (int j = 1; j < N; j++) hold[j] = !(sz[N-1-j] & MASK[N-1-j]);
        for (int k = 0; k < len; k++) begin
            f = r[N-1] ^ pl[k];
            r = ((r << 1) & hold) ^ (f ? poly : '0);
        end
        return r;
    endfunction

    function automatic logic frame_bit(input int idx, input int len, input logic [N-1:0] cb);
        if (idx < len) return pl[idx];
        return cb[N-1-(idx-len)];
    endfunction

    task automatic load_digits();
        logic [7:0] b;
        for (int i = 0; i < 9; i++) begin
            b = 8'h31 + 8'(i);
            for (int j = 0; j < 8; j++) pl[8*i+j] = b[7-j];
        end
    endtask

    // ---------------- expectation state ----------------
    int           frame_id  = 0;   // driver: bumped on each start/reset
    bit           live      = 0;   // driver: a done is expected for frame_id
    bit           timed     = 0;
    int           exp_lat   = 0;
    int           t_start   = 0;
    logic [N-1:0] exp_calc  = '0;
    bit           exp_err   = 0;
    int           done_for    = 0; // compare: frame whose done was seen
    int           cleared_for = 0;
    bit           cur_ok  = 0;
    bit           cur_err = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                check("done_expected", 32'(live && (done_for != frame_id)), 32'd1);
                if (live && (done_for != frame_id)) begin
                    check("crc_calc", 32'(crc_calc), 32'(exp_calc));
                    check("crc_ok", 32'(crc_ok), 32'(!exp_err));
                    check("crc_err", 32'(crc_err), 32'(exp_err));
                    if (timed) check("done_latency", 32'(cyc - t_start), 32'(exp_lat));
                    done_for    <= frame_id;
                    cleared_for <= frame_id;
                    cur_ok      <= !exp_err;
                    cur_err     <= exp_err;
                end
            end else begin
                check("ok_sticky", 32'(crc_ok), 32'((cleared_for != frame_id) ? 1'b0 : cur_ok));
                check("err_sticky", 32'(crc_err), 32'((cleared_for != frame_id) ? 1'b0 : cur_err));
                if (cleared_for != frame_id) begin
                    cur_ok      <= 1'b0;
                    cur_err     <= 1'b0;
                    cleared_for <= frame_id;
                end
            end
        end
    end

    // mode: 0 normal, 1 abort at beat kill_at, 2 reset at beat kill_at
    task automatic send_frame(input int len, input logic [N-1:0] init, input logic [N-1:0] poly,
                              input logic [N-2:0] sz, input logic [N-1:0] cbits, input bit gaps,
                              input int kill_at, input int mode, input bit poke);
        int total;
        int idx;
        int guard;
        bit v;
        total    = len + N;
        idx      = 0;
        guard    = 0;
        exp_calc = model_crc(len, init, poly, sz);
        exp_err  = (cbits != exp_calc);
        start         = 1'b1;
        payload_len   = LW'(len);
        crc_init      = init;
        crc_poly      = poly;
        crc_poly_size = sz;
        t_start       = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
        frame_id++;
        live     = 1;
        timed    = !gaps;
        exp_lat  = total + 1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(bit_ready), 32'd1);
        while (idx < total && guard < 4000) begin
            v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bit_valid = v;
            bit_in    = v ? frame_bit(idx, len, cbits) : 1'($urandom_range(0, 1));
            if (poke && idx == len / 2) begin
                start       = 1'b1;
                payload_len = LW'(3);
                crc_poly    = ~poly;
                crc_init    = ~init;
            end
            if (mode == 1 && idx == kill_at) abort = 1'b1;
            check("ready_in_frame", 32'(bit_ready), 32'd1);
            if (mode == 2 && idx == kill_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_bit_ready", 32'(bit_ready), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_crc_ok", 32'(crc_ok), 32'd0);
                check("rst_crc_err", 32'(crc_err), 32'd0);
                check("rst_crc_calc", 32'(crc_calc), 32'd0);
                frame_id++;
                live = 0;
                @(posedge clk); #1;
                rst       = 1'b0;
                bit_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (mode == 1 && idx == kill_at) begin
                live      = 0;
                bit_valid = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_ready", 32'(bit_ready), 32'd0);
                return;
            end
            if (v) idx++;
            guard++;
        end
        bit_valid = 1'b0;
        if (idx < total) check("beat_timeout", 32'(idx), 32'(total));
        for (int k = 0; k < 3 && done_for != frame_id; k++) @(posedge clk);
        #1;
        check("done_seen", 32'(done_for == frame_id), 32'd1);
        live = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rc;
        logic [N-1:0] ri;
        logic [N-1:0] rp;
        logic [N-2:0] rs;
        int           rl;
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        payload_len = '0; crc_init = '0; crc_poly = '0; crc_poly_size = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bit_ready", 32'(bit_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_crc_ok", 32'(crc_ok), 32'd0);
        check("reset_crc_err", 32'(crc_err), 32'd0);
        check("reset_crc_calc", 32'(crc_calc), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model with known CRC-8 values.
        for (int i = 0; i < 8; i++) pl[i] = (i == 7);
        check("model_byte01", 32'(model_crc(8, 8'h00, 8'h07, 7'h00)), 32'h07);
        check("model_len0", 32'(model_crc(0, 8'hA5, 8'h07, 7'h00)), 32'hA5);
        load_digits();
        check("model_check_value", 32'(model_crc(72, 8'h00, 8'h07, 7'h00)), 32'hF4);

        // "123456789" with correct CRC, then LSB-flipped CRC.
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF4, 0, -1, 0, 0);
        check("lit_calc_F4", 32'(crc_calc), 32'hF4);
        check("lit_ok_F4", 32'(crc_ok), 32'd1);
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF5, 0, -1, 0, 0);
        check("lit_err_F5", 32'(crc_err), 32'd1);
        check("lit_ok_F5", 32'(crc_ok), 32'd0);

        // Empty payload: CRC is the seed.
        send_frame(0, 8'hA5, 8'h07, 7'h00, 8'hA5, 0, -1, 0, 0);
        check("lit_len0_ok", 32'(crc_ok), 32'd1);
        check("lit_len0_calc", 32'(crc_calc), 32'hA5);
        send_frame(0, 8'hA5, 8'h07, 7'h00, 8'h25, 0, -1, 0, 0);
        check("lit_len0_err", 32'(crc_err), 32'd1);

        // Gapped stream with a stray start mid-frame.
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF4, 1, -1, 0, 1);
        check("lit_gap_calc", 32'(crc_calc), 32'hF4);
        check("lit_gap_ok", 32'(crc_ok), 32'd1);

        // Abort on payload bit 40, then a clean frame.
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF4, 0, 40, 1, 0);
        check("abort_ok_clear", 32'(crc_ok), 32'd0);
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF4, 0, -1, 0, 0);
        check("after_abort_ok", 32'(crc_ok), 32'd1);

        // Reset during CHECK, then a clean frame.
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF4, 0, 75, 2, 0);
        send_frame(72, 8'h00, 8'h07, 7'h00, 8'hF4, 0, -1, 0, 0);
        check("after_rst_ok", 32'(crc_ok), 32'd1);

        // Randomised frames: random payload, seed, poly, size, gaps, pass/fail.
        for (int f = 0; f < 24; f++) begin
            rl = int'($urandom_range(0, 100));
            for (int i = 0; i < rl; i++) pl[i] = 1'($urandom_range(0, 1));
            ri = N'($urandom);
            rp = N'($urandom);
            rs = ($urandom_range(0, 1) == 1) ? (N-1)'($urandom) : '0;
            rc = model_crc(rl, ri, rp, rs);
            if ($urandom_range(0, 1) == 1) rc = rc ^ (N'(1) << $urandom_range(0, N-1));
            send_frame(rl, ri, rp, rs, rc, 1'($urandom_range(0, 1)), -1, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_crc_check_rx
